// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the Data_Memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    PORT0,
    PORT1,
    PORT_NONE
  } port_id_e;

  localparam int unsigned MAX_WAIT_DEF = 3;
  localparam int unsigned WAIT_W       = 4;
  localparam int unsigned STAT_W       = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of single-port Data_Memory: port 0 has priority,
// port 1 is forced through after MAX_WAIT denied cycles. Optional DMEM_ARB_STATS_EN adds counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] p0_gnt_cnt,
  output logic [STAT_W-1:0] p1_gnt_cnt,
  output logic [STAT_W-1:0] stall_cnt
`endif
);

  port_id_e            w_sel;
  logic [WAIT_W-1:0]   w_wait_cnt;
  logic                w_wait_full;
  logic                r_p0_rvalid;
  logic                r_p1_rvalid;
  logic [DW-1:0]       r_p0_rdata;
  logic [DW-1:0]       r_p1_rdata;

  assign w_wait_full = (w_wait_cnt == WAIT_W'(MAX_WAIT));

  sat_counter #(
    .WIDTH (WAIT_W),
    .LIMIT (WAIT_W'(MAX_WAIT))
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (p1_req && !p1_gnt),
    .clr   (p1_gnt || !p1_req),
    .count (w_wait_cnt)
  );

  always_comb begin
    w_sel = PORT_NONE;
    if (reset) begin
      w_sel = PORT_NONE;
    end else if (p1_req && w_wait_full) begin
      w_sel = PORT1;
    end else if (p0_req) begin
      w_sel = PORT0;
    end else if (p1_req) begin
      w_sel = PORT1;
    end
  end

  assign p0_gnt = (w_sel == PORT0);
  assign p1_gnt = (w_sel == PORT1);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (w_sel)
      PORT0: begin
        mem_addr  = p0_addr;
        mem_wdata = p0_wdata;
        mem_we    = p0_we;
      end
      PORT1: begin
        mem_addr  = p1_addr;
        mem_wdata = p1_wdata;
        mem_we    = p1_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      r_p0_rvalid <= p0_gnt && !p0_we;
      r_p1_rvalid <= p1_gnt && !p1_we;
      if (p0_gnt && !p0_we) r_p0_rdata <= mem_rdata;
      if (p1_gnt && !p1_we) r_p1_rdata <= mem_rdata;
    end
  end

  // Masking with reset kills the response of a read granted just before reset.
  assign p0_rvalid = r_p0_rvalid && !reset;
  assign p1_rvalid = r_p1_rvalid && !reset;
  assign p0_rdata  = reset ? '0 : r_p0_rdata;
  assign p1_rdata  = reset ? '0 : r_p1_rdata;

`ifdef DMEM_ARB_STATS_EN
  sat_counter #(.WIDTH(STAT_W)) u_p0_gnt_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (p0_gnt),
    .clr   (1'b0),
    .count (p0_gnt_cnt)
  );

  sat_counter #(.WIDTH(STAT_W)) u_p1_gnt_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (p1_gnt),
    .clr   (1'b0),
    .count (p1_gnt_cnt)
  );

  sat_counter #(.WIDTH(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   ((p0_req && !p0_gnt) || (p1_req && !p1_gnt)),
    .clr   (1'b0),
    .count (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, corner sequences, randomized run vs. reference model.
module tb_dmem_arbiter;

  localparam int unsigned MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] p0_gnt_cnt, p1_gnt_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .p0_gnt_cnt (p0_gnt_cnt),
    .p1_gnt_cnt (p1_gnt_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // Data_Memory stand-in: combinational read, write on rising edge.
  logic [31:0] mem [0:255] = '{default: '0};
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  // Reference model state.
  logic [31:0] ref_mem [0:255] = '{default: '0};
  int unsigned deny;
  logic        mrv0, mrv1;
  logic [31:0] mrd0, mrd1;
  int unsigned s0, s1, sst;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic rst,
                     input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                     output logic eg0, output logic eg1,
                     output logic ag0, output logic ag1, output logic arv0, output logic arv1);
    logic        ewe;
    logic [31:0] ead, ewd;
    reset = rst;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!rst) begin
      if (r1 && deny >= MAX_WAIT) eg1 = 1'b1;
      else if (r0)                eg0 = 1'b1;
      else if (r1)                eg1 = 1'b1;
    end
    ewe = eg0 ? w0 : (eg1 ? w1 : 1'b0);
    ead = eg0 ? a0 : (eg1 ? a1 : 32'h0);
    ewd = eg0 ? d0 : (eg1 ? d1 : 32'h0);
    @(negedge clk);
    ag0 = p0_gnt; ag1 = p1_gnt; arv0 = p0_rvalid; arv1 = p1_rvalid;
    chk("p0_gnt", p0_gnt, eg0);
    chk("p1_gnt", p1_gnt, eg1);
    chk("mem_we", mem_we, ewe);
    chk("mem_addr", mem_addr, ead);
    chk("mem_wdata", mem_wdata, ewd);
    chk("p0_rvalid", p0_rvalid, rst ? 1'b0 : mrv0);
    chk("p1_rvalid", p1_rvalid, rst ? 1'b0 : mrv1);
    chk("p0_rdata", p0_rdata, rst ? 32'h0 : mrd0);
    chk("p1_rdata", p1_rdata, rst ? 32'h0 : mrd1);
`ifdef DMEM_ARB_STATS_EN
    chk("p0_gnt_cnt", {16'h0, p0_gnt_cnt}, s0);
    chk("p1_gnt_cnt", {16'h0, p1_gnt_cnt}, s1);
    chk("stall_cnt", {16'h0, stall_cnt}, sst);
`endif
    @(posedge clk);
    if (rst) begin
      deny = 0; mrv0 = 1'b0; mrv1 = 1'b0; mrd0 = '0; mrd1 = '0;
      s0 = 0; s1 = 0; sst = 0;
    end else begin
      mrv0 = eg0 && !w0;
      mrv1 = eg1 && !w1;
      if (mrv0) mrd0 = ref_mem[a0[7:0]];
      if (mrv1) mrd1 = ref_mem[a1[7:0]];
      if (eg0 && w0) ref_mem[a0[7:0]] = d0;
      if (eg1 && w1) ref_mem[a1[7:0]] = d1;
      if (!r1 || eg1) deny = 0;
      else if (deny < MAX_WAIT) deny++;
      if (eg0 && s0 < 65535) s0++;
      if (eg1 && s1 < 65535) s1++;
      if (((r0 && !eg0) || (r1 && !eg1)) && sst < 65535) sst++;
    end
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        eg0, eg1, erv0, erv1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                              logic eg0, logic eg1, logic erv0, logic erv1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.erv0 = erv0; v.erv1 = erv1;
    return v;
  endfunction

  initial begin
    logic g0, g1, a0g, a1g, rv0, rv1;
    logic        pend0, pend1, pw0, pw1, rst;
    logic [31:0] pa0, pa1, pd0, pd1;

    deny = 0; mrv0 = 0; mrv1 = 0; mrd0 = '0; mrd1 = '0; s0 = 0; s1 = 0; sst = 0;
    reset = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    @(posedge clk);
    #1;

    // reset with a pending write; p0 write/read; p1 alone; simultaneous writes to one address
    tbl.push_back(mk(1, 1,1,32'h3,32'hDEAD, 0,0,0,0,          0,0,0,0));
    tbl.push_back(mk(1, 1,1,32'h3,32'hDEAD, 0,0,0,0,          0,0,0,0));
    tbl.push_back(mk(0, 1,1,32'h1,32'hA,    0,0,0,0,          1,0,0,0));
    tbl.push_back(mk(0, 1,0,32'h1,32'h0,    0,0,0,0,          1,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0,            0,0,0,0,          0,0,1,0));
    tbl.push_back(mk(0, 0,0,0,0,            1,1,32'h60,32'h7, 0,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0,            1,0,32'h60,32'h0, 0,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0,            0,0,0,0,          0,0,0,1));
    tbl.push_back(mk(0, 1,1,32'h5,32'h1,    1,1,32'h5,32'h2,  1,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0,            1,1,32'h5,32'h2,  0,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0,            1,0,32'h5,32'h0,  0,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0,            0,0,0,0,          0,0,0,1));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
          tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, g0, g1, a0g, a1g, rv0, rv1);
      chk($sformatf("tbl%0d_p0_gnt", i), a0g, tbl[i].eg0);
      chk($sformatf("tbl%0d_p1_gnt", i), a1g, tbl[i].eg1);
      chk($sformatf("tbl%0d_p0_rvalid", i), rv0, tbl[i].erv0);
      chk($sformatf("tbl%0d_p1_rvalid", i), rv1, tbl[i].erv1);
      if (i == 1) chk("reset_mem3_unchanged", mem[3], 32'h0);
    end
    chk("p0_rdata_A", p0_rdata, 32'hA);
    chk("p1_rdata_addr5", p1_rdata, 32'h2);
    chk("mem5_final", mem[5], 32'h2);

    // continuous reads on both ports: p0,p0,p0,p1 repeating
    for (int k = 0; k < 16; k++) begin
      cyc(0, 1,0,32'h2,0, 1,0,32'h60,0, g0, g1, a0g, a1g, rv0, rv1);
      chk($sformatf("rr%0d_p1_gnt", k), a1g, (k % 4) == 3);
      chk($sformatf("rr%0d_p1_rvalid", k), rv1, (k > 0) && ((k % 4) == 0));
    end

    // reset right after a granted p1 read
    cyc(0, 0,0,0,0, 1,0,32'h5,0, g0, g1, a0g, a1g, rv0, rv1);
    cyc(1, 1,0,32'h2,0, 1,0,32'h5,0, g0, g1, a0g, a1g, rv0, rv1);
    chk("rst_kills_p1_rvalid", rv1, 1'b0);
`ifdef DMEM_ARB_STATS_EN
    chk("rst_stats_zero", {16'h0, p0_gnt_cnt | p1_gnt_cnt | stall_cnt}, 32'h0);
`endif
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1,0,32'h2,0, 1,0,32'h5,0, g0, g1, a0g, a1g, rv0, rv1);
      chk($sformatf("postrst%0d_p1_gnt", k), a1g, k == 3);
    end

    // randomized requesters that hold their request until granted
    pend0 = 0; pend1 = 0; pw0 = 0; pw1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int n = 0; n < 600; n++) begin
      if (!pend0 && ($urandom % 3 != 0)) begin
        pend0 = 1; pw0 = $urandom % 2; pa0 = $urandom % 16; pd0 = $urandom;
      end
      if (!pend1 && ($urandom % 2 == 0)) begin
        pend1 = 1; pw1 = $urandom % 2; pa1 = $urandom % 16; pd1 = $urandom;
      end
      rst = ($urandom % 64) == 0;
      cyc(rst, pend0, pend0 & pw0, pend0 ? pa0 : 32'h0, pend0 ? pd0 : 32'h0,
          pend1, pend1 & pw1, pend1 ? pa1 : 32'h0, pend1 ? pd1 : 32'h0,
          g0, g1, a0g, a1g, rv0, rv1);
      if (g0) pend0 = 0;
      if (g1) pend1 = 0;
    end
    for (int a = 0; a < 16; a++) chk($sformatf("mem%0d_final", a), mem[a], ref_mem[a]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
